// File: rtl/pg_carry_resolve.sv
// pg_carry_resolve: pipelined Kogge-Stone carry resolution of Pi/Gi vectors into a registered binary sum.
// Defining PG_CHECK_EN adds a sticky Pi/Gi overlap detector on pg_err; otherwise pg_err is tied low.
module pg_carry_resolve #(
    parameter int WIDTH     = 65,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Pi,
    input  logic [WIDTH-1:0] Gi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             pg_err
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int STAGES = (LEVELS + REG_EVERY - 1) / REG_EVERY;

    logic             adv;
    logic [WIDTH-1:0] stg_p  [STAGES];
    logic [WIDTH-1:0] stg_g  [STAGES];
    logic [WIDTH-1:0] stg_pi [STAGES];
    logic             stg_v  [STAGES+1];

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = stg_v[STAGES];

    assign stg_p[0]  = Pi;
    assign stg_g[0]  = Gi;
    assign stg_pi[0] = Pi;
    assign stg_v[0]  = in_valid;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = s * REG_EVERY;
        localparam int HI = ((s + 1) * REG_EVERY < LEVELS) ? (s + 1) * REG_EVERY : LEVELS;

        logic [WIDTH-1:0] p_c;
        logic [WIDTH-1:0] g_c;
        logic             v_q;

        always_comb begin
            p_c = stg_p[s];
            g_c = stg_g[s];
            for (int k = LO; k < HI; k++) begin
                g_c = g_c | (p_c & (g_c << (1 << k)));
                p_c = p_c & ((p_c << (1 << k)) | ~({WIDTH{1'b1}} << (1 << k)));
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
            end else if (adv) begin
                v_q <= stg_v[s];
            end
        end

        assign stg_v[s+1] = v_q;

        if (s < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] p_q;
            logic [WIDTH-1:0] g_q;
            logic [WIDTH-1:0] pi_q;

            // Bubbles leave the data registers untouched.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_q  <= '0;
                    g_q  <= '0;
                    pi_q <= '0;
                end else if (adv && stg_v[s]) begin
                    p_q  <= p_c;
                    g_q  <= g_c;
                    pi_q <= stg_pi[s];
                end
            end

            assign stg_p[s+1]  = p_q;
            assign stg_g[s+1]  = g_q;
            assign stg_pi[s+1] = pi_q;
        end else begin : g_last
            logic [WIDTH-1:0] sum_q;

            // Carry into bit i is the group generate of [i-1:0]; the top carry shifts out.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_q <= '0;
                end else if (adv && stg_v[s]) begin
                    sum_q <= stg_pi[s] ^ (g_c << 1);
                end
            end

            assign sum = sum_q;
        end
    end

`ifdef PG_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pg_err <= 1'b0;
        end else if (in_valid && adv && (|(Pi & Gi))) begin
            pg_err <= 1'b1;
        end
    end
`else
    assign pg_err = 1'b0;
`endif

endmodule
